// File: rtl/uart_alu_interface_pkg.sv
// Shared types and constants for the UART-to-ALU command bridge.
// State encoding plus the opcode map agreed with the ALU.
package uart_alu_interface_pkg;

  localparam int NOP_BITS_DEF = 6;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    WAIT_TX = 3'd4
  } state_e;

  localparam logic [NOP_BITS_DEF-1:0] OP_ADD = 6'h20;
  localparam logic [NOP_BITS_DEF-1:0] OP_SUB = 6'h22;
  localparam logic [NOP_BITS_DEF-1:0] OP_AND = 6'h24;
  localparam logic [NOP_BITS_DEF-1:0] OP_OR  = 6'h25;
  localparam logic [NOP_BITS_DEF-1:0] OP_XOR = 6'h26;
  localparam logic [NOP_BITS_DEF-1:0] OP_SRA = 6'h03;
  localparam logic [NOP_BITS_DEF-1:0] OP_SRL = 6'h02;
  localparam logic [NOP_BITS_DEF-1:0] OP_NOR = 6'h27;

endpackage

// File: rtl/uart_alu_interface_edge.sv
// Rising-edge detector for level-style done flags.
// Resets high so a flag already asserted at reset release is not seen as an edge.
module rise_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic pulse_o
);

  logic sig_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sig_q <= 1'b1;
    else       sig_q <= sig_i;
  end

  assign pulse_o = sig_i & ~sig_q;

endmodule

// File: rtl/uart_alu_interface.sv
// Collects A, B, opcode bytes from the UART receiver, runs the ALU,
// and hands the result to the UART transmitter.
module uart_alu_interface
  import uart_alu_interface_pkg::*;
#(
  parameter int NDATA_BITS     = 8,
  parameter int NOP_BITS       = NOP_BITS_DEF,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NDATA_BITS-1:0] i_rx_data,
  input  logic                  i_rx_done,
  input  logic [NDATA_BITS-1:0] i_alu_result,
  input  logic                  i_tx_done,
  output logic [NDATA_BITS-1:0] o_alu_a,
  output logic [NDATA_BITS-1:0] o_alu_b,
  output logic [NOP_BITS-1:0]   o_alu_op,
  output logic [NDATA_BITS-1:0] o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_busy
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] CNT_MAX =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                state_q, state_d;
  logic [NDATA_BITS-1:0] a_q, a_d;
  logic [NDATA_BITS-1:0] b_q, b_d;
  logic [NOP_BITS-1:0]   op_q, op_d;
  logic [NDATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic [TW-1:0]         cnt_q, cnt_d;

  logic rx_pulse;
  logic tx_pulse;
  logic in_gap;
  logic timeout_hit;

  rise_edge_detect u_rx_edge (
    .clk_i   (i_clock),
    .rst_i   (i_reset),
    .sig_i   (i_rx_done),
    .pulse_o (rx_pulse)
  );

  rise_edge_detect u_tx_edge (
    .clk_i   (i_clock),
    .rst_i   (i_reset),
    .sig_i   (i_tx_done),
    .pulse_o (tx_pulse)
  );

  assign in_gap = (state_q == WAIT_B) || (state_q == WAIT_OP);

  // A byte arriving on the last allowed cycle beats the timeout.
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && in_gap &&
                       !rx_pulse && (cnt_q == CNT_MAX);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    cnt_d      = '0;

    if ((TIMEOUT_CYCLES > 0) && in_gap && !rx_pulse)
      cnt_d = cnt_q + 1'b1;

    unique case (state_q)
      WAIT_A: begin
        if (rx_pulse) begin
          a_d     = i_rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (rx_pulse) begin
          b_d     = i_rx_data;
          state_d = WAIT_OP;
        end else if (timeout_hit) begin
          state_d = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (rx_pulse) begin
          op_d    = i_rx_data[NOP_BITS-1:0];
          state_d = EXEC;
        end else if (timeout_hit) begin
          state_d = WAIT_A;
        end
      end
      EXEC: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        state_d    = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_pulse) state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase

    if (timeout_hit) cnt_d = '0;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_alu_a    = a_q;
  assign o_alu_b    = b_q;
  assign o_alu_op   = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = (state_q == EXEC) || (state_q == WAIT_TX);

endmodule

// File: tb/tb_uart_alu_interface.sv
// Scoreboard bench for uart_alu_interface with a behavioural ALU
// and directed receiver/transmitter stimulus.
module tb_uart_alu_interface;
  import uart_alu_interface_pkg::*;

  localparam int NB = 8;
  localparam int NO = 6;

  logic          clk = 1'b0;
  logic          i_reset;
  logic [NB-1:0] i_rx_data;
  logic          i_rx_done;
  logic [NB-1:0] i_alu_result;
  logic          i_tx_done;
  logic [NB-1:0] o_alu_a;
  logic [NB-1:0] o_alu_b;
  logic [NO-1:0] o_alu_op;
  logic [NB-1:0] o_tx_data;
  logic          o_tx_start;
  logic          o_busy;

  uart_alu_interface #(
    .NDATA_BITS     (NB),
    .NOP_BITS       (NO),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .i_alu_result (i_alu_result),
    .i_tx_done    (i_tx_done),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .o_tx_data    (o_tx_data),
    .o_tx_start   (o_tx_start),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    i_alu_result = '0;
    case (o_alu_op)
      OP_ADD:  i_alu_result = o_alu_a + o_alu_b;
      OP_SUB:  i_alu_result = o_alu_a - o_alu_b;
      OP_AND:  i_alu_result = o_alu_a & o_alu_b;
      OP_OR:   i_alu_result = o_alu_a | o_alu_b;
      OP_XOR:  i_alu_result = o_alu_a ^ o_alu_b;
      OP_SRA:  i_alu_result = $signed(o_alu_a) >>> o_alu_b[2:0];
      OP_SRL:  i_alu_result = o_alu_a >> o_alu_b[2:0];
      OP_NOR:  i_alu_result = ~(o_alu_a | o_alu_b);
      default: i_alu_result = '0;
    endcase
  end

  typedef struct {
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic [NO-1:0] op;
    logic [NB-1:0] res;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_starts = 0;
  int   exp_starts = 0;
  logic prev_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req,
               $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every transmit request is matched against the scoreboard.
  always @(negedge clk) begin
    if (i_reset) begin
      prev_start = 1'b0;
    end else begin
      if (o_tx_start) begin
        n_starts++;
        chk("start_width", {31'd0, prev_start}, 32'd0);
        chk("busy_at_start", {31'd0, o_busy}, 32'd1);
        chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("alu_a", {24'd0, o_alu_a}, {24'd0, e.a});
          chk("alu_b", {24'd0, o_alu_b}, {24'd0, e.b});
          chk("alu_op", {26'd0, o_alu_op}, {26'd0, e.op});
          chk("tx_data", {24'd0, o_tx_data}, {24'd0, e.res});
          chk("start_cycle", cyc, e.cyc);
        end
      end
      prev_start = o_tx_start;
    end
  end

  task automatic raise_byte(input logic [NB-1:0] b, output int p);
    @(posedge clk);
    #1;
    i_rx_data = b;
    i_rx_done = 1'b1;
    p = cyc;
  endtask

  task automatic drop_byte(input int hold);
    repeat (hold) @(posedge clk);
    #1 i_rx_done = 1'b0;
  endtask

  task automatic push_exp(input logic [NB-1:0] a, input logic [NB-1:0] b,
                          input logic [NO-1:0] op, input logic [NB-1:0] r,
                          input int p);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.res = r; e.cyc = p + 2;
    exp_q.push_back(e);
    exp_starts++;
  endtask

  task automatic send_cmd(input logic [NB-1:0] a, input logic [NB-1:0] b,
                          input logic [NB-1:0] opb, input logic [NB-1:0] r,
                          input int hold);
    int p;
    raise_byte(a, p);
    drop_byte(hold);
    raise_byte(b, p);
    drop_byte(hold);
    raise_byte(opb, p);
    push_exp(a, b, opb[NO-1:0], r, p);
    drop_byte(hold);
  endtask

  task automatic wait_starts();
    int t = 0;
    while (n_starts < exp_starts && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("start_seen", n_starts, exp_starts);
  endtask

  task automatic pulse_tx();
    @(posedge clk);
    #1 i_tx_done = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("idle_after_tx", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic wait_until(input int c);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    i_reset   = 1'b1;
    i_rx_data = '0;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    #1;
    chk("rst_outputs", {o_alu_a, o_alu_b, o_tx_data, o_alu_op, o_tx_start,
                        o_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;

    // Basic ADD.
    send_cmd(8'h05, 8'h03, 8'h20, 8'h08, 2);
    wait_starts();
    pulse_tx();

    // Long done level: each byte accepted once.
    send_cmd(8'hFF, 8'h01, 8'h22, 8'hFE, 40);
    wait_starts();
    chk("busy_long", {31'd0, o_busy}, 32'd1);
    pulse_tx();

    // Byte during WAIT_TX is dropped.
    send_cmd(8'h0C, 8'h01, 8'h26, 8'h0D, 2);
    wait_starts();
    raise_byte(8'hAA, p);
    drop_byte(2);
    chk("discard_a_held", {24'd0, o_alu_a}, 32'h0C);
    pulse_tx();
    send_cmd(8'h10, 8'h20, 8'h24, 8'h00, 2);
    wait_starts();
    pulse_tx();

    // Timeout abandons the half-built command.
    raise_byte(8'h11, p);
    drop_byte(2);
    repeat (120) @(posedge clk);
    #1 chk("timeout_a_held", {24'd0, o_alu_a}, 32'h11);
    send_cmd(8'h22, 8'h33, 8'h20, 8'h55, 2);
    wait_starts();
    pulse_tx();

    // Byte on the last allowed cycle wins.
    raise_byte(8'h40, p);
    drop_byte(2);
    wait_until(p + 99);
    raise_byte(8'h02, p);
    drop_byte(2);
    raise_byte(8'h20, p);
    push_exp(8'h40, 8'h02, 6'h20, 8'h42, p);
    drop_byte(2);
    wait_starts();
    pulse_tx();

    // One cycle later the command is already abandoned.
    raise_byte(8'h50, p);
    drop_byte(2);
    wait_until(p + 100);
    send_cmd(8'h60, 8'h07, 8'h20, 8'h67, 2);
    wait_starts();
    pulse_tx();

    // Reset in WAIT_OP with receiver flag held through release.
    raise_byte(8'h0A, p);
    drop_byte(2);
    raise_byte(8'h0B, p);
    drop_byte(2);
    #3;
    i_rx_data = 8'h77;
    i_rx_done = 1'b1;
    i_reset   = 1'b1;
    #1;
    chk("rst1_a", {24'd0, o_alu_a}, 32'd0);
    chk("rst1_b", {24'd0, o_alu_b}, 32'd0);
    @(posedge clk);
    #1 i_reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("rst1_no_byte", {24'd0, o_alu_a}, 32'd0);
    i_rx_done = 1'b0;
    send_cmd(8'h05, 8'h03, 8'h22, 8'h02, 2);
    wait_starts();
    pulse_tx();

    // Reset in WAIT_TX with both flags high.
    send_cmd(8'h09, 8'h04, 8'h25, 8'h0D, 2);
    wait_starts();
    #3;
    i_rx_data = 8'h66;
    i_rx_done = 1'b1;
    i_tx_done = 1'b1;
    i_reset   = 1'b1;
    #1;
    chk("rst2_tx_data", {24'd0, o_tx_data}, 32'd0);
    chk("rst2_op_busy", {25'd0, o_alu_op, o_busy}, 32'd0);
    @(posedge clk);
    #1 i_reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("rst2_no_byte", {24'd0, o_alu_a}, 32'd0);
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;

    // Opcode upper bits ignored.
    send_cmd(8'h0F, 8'hF0, 8'hE5, 8'hFF, 2);
    wait_starts();
    pulse_tx();

    repeat (5) @(posedge clk);
    #1 chk("sb_drained", exp_q.size(), 32'd0);
    chk("start_total", n_starts, exp_starts);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
